hs_arith_stream_uminimize: RTL



---
 rtl/hs_arith_stream_uminimize.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hs_arith_stream_uminimize.sv
// Streaming unsigned arg-min/arg-max reducer: one registered result per frame, valid/ready on both sides.
// Build with HS_ARITH_STREAM_MINIMIZE_OVF_EN defined to add the m_overflow port and frame-length overflow flag.
package hs_ifr_misc_typedefs_pkg;
  typedef enum logic {BOOL_FALSE = 1'b0, BOOL_TRUE = 1'b1} bool_t;
endpackage

module hs_arith_stream_uminimize
  import hs_ifr_misc_typedefs_pkg::*;
#(
  parameter int    DATA_WIDTH      = 32,
  parameter int    INDEX_WIDTH     = 8,
  parameter bool_t ENABLE_AUX_PATH = BOOL_TRUE,
  parameter type   AUX_DATA_TYPE   = logic,
  parameter bool_t FIND_MAX        = BOOL_FALSE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  AUX_DATA_TYPE           s_aux,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  m_value,
  output AUX_DATA_TYPE           m_aux,
  output logic [INDEX_WIDTH-1:0] m_index,
`ifdef HS_ARITH_STREAM_MINIMIZE_OVF_EN
  output logic                   m_overflow,
`endif
  output logic                   m_valid,
  input  logic                   m_ready
);

  logic                   accept;
  logic                   first;
  logic                   better;
  logic                   take;
  logic [INDEX_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  cand_value;
  logic [INDEX_WIDTH-1:0] cand_index;
  logic [DATA_WIDTH-1:0]  nxt_value;
  logic [INDEX_WIDTH-1:0] nxt_index;

  // Single result slot: a consumed result can be replaced in the same cycle.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Strict compare so ties keep the earliest beat.
  assign better    = (FIND_MAX == BOOL_TRUE) ? (s_data > cand_value) : (s_data < cand_value);
  assign take      = first || better;
  assign nxt_value = take ? s_data : cand_value;
  assign nxt_index = first ? '0 : (better ? cnt : cand_index);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first      <= 1'b1;
      cnt        <= '0;
      cand_value <= '0;
      cand_index <= '0;
      m_value    <= '0;
      m_index    <= '0;
      m_valid    <= 1'b0;
    end else begin
      if (accept) begin
        cand_value <= nxt_value;
        cand_index <= nxt_index;
        if (s_last) begin
          first   <= 1'b1;
          cnt     <= '0;
          m_value <= nxt_value;
          m_index <= nxt_index;
        end else begin
          first <= 1'b0;
          cnt   <= cnt + INDEX_WIDTH'(1);
        end
      end
      if (accept && s_last) begin
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  generate
    if (ENABLE_AUX_PATH == BOOL_TRUE) begin : g_aux
      AUX_DATA_TYPE cand_aux;
      AUX_DATA_TYPE res_aux;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cand_aux <= '0;
          res_aux  <= '0;
        end else if (accept) begin
          if (take) begin
            cand_aux <= s_aux;
          end
          if (s_last) begin
            res_aux <= take ? s_aux : cand_aux;
          end
        end
      end

      assign m_aux = res_aux;
    end else begin : g_no_aux
      assign m_aux = '0;
    end
  endgenerate

`ifdef HS_ARITH_STREAM_MINIMIZE_OVF_EN
  logic ovf_flag;
  logic nxt_ovf;

  // A non-first beat seeing cnt == 0 means the counter has wrapped past 2^INDEX_WIDTH beats.
  assign nxt_ovf = !first && (ovf_flag || (cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag   <= 1'b0;
      m_overflow <= 1'b0;
    end else if (accept) begin
      ovf_flag <= s_last ? 1'b0 : nxt_ovf;
      if (s_last) begin
        m_overflow <= nxt_ovf;
      end
    end
  end
`endif

endmodule
